// File: rtl/instruction_fetch_unit.sv
// Fetch stage for a SPARC-style control unit. It holds the PC/nPC pair,
// reads one instruction word from RAM, and presents it on IR_Out until the
// control unit reports exec_done. PC/nPC then advance with delay-slot
// semantics. Misaligned PCs and memory timeouts raise a sticky fault.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16,
    parameter logic [5:0]  RD_OPCODE   = 6'b000000
) (
    input  logic        Clk,
    input  logic        RESET,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic [5:0]  RAM_OpCode,
    input  logic        MFC,
    input  logic [31:0] mem_data,
    output logic [31:0] IR_Out,
    output logic        ir_valid,
    input  logic        exec_done,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic [31:0] PC_out,
    output logic [31:0] nPC_out,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int TIMER_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] CODE_NONE      = 2'b00;
    localparam logic [1:0] CODE_MISALIGN  = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT   = 2'b10;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_FAULT
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        pc_reg, pc_next;
    logic [31:0]        npc_reg, npc_next;
    logic [31:0]        ir_reg, ir_next;
    logic               ir_valid_reg, ir_valid_next;
    logic [31:0]        mem_addr_reg, mem_addr_next;
    logic               mem_read_reg, mem_read_next;
    logic               fault_reg, fault_next;
    logic [1:0]         fault_code_reg, fault_code_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;

    // State register: reset wins at every edge, including mid-WAIT, so a late MFC finds FETCH
    always_ff @(posedge Clk) begin
        if (RESET) begin
            state_reg      <= ST_FETCH;
            pc_reg         <= RESET_PC;
            npc_reg        <= RESET_PC + 32'd4;
            ir_reg         <= 32'd0;
            ir_valid_reg   <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_read_reg   <= 1'b0;
            fault_reg      <= 1'b0;
            fault_code_reg <= CODE_NONE;
            timer_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            npc_reg        <= npc_next;
            ir_reg         <= ir_next;
            ir_valid_reg   <= ir_valid_next;
            mem_addr_reg   <= mem_addr_next;
            mem_read_reg   <= mem_read_next;
            fault_reg      <= fault_next;
            fault_code_reg <= fault_code_next;
            timer_reg      <= timer_next;
        end
    end

    // Next-state and datapath updates; every register holds unless its state says otherwise
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        npc_next        = npc_reg;
        ir_next         = ir_reg;
        ir_valid_next   = ir_valid_reg;
        mem_addr_next   = mem_addr_reg;
        mem_read_next   = mem_read_reg;
        fault_next      = fault_reg;
        fault_code_next = fault_code_reg;
        timer_next      = timer_reg;

        case (state_reg)
            ST_FETCH: begin
                if (pc_reg[1:0] != 2'b00) begin
                    // A misaligned target is only caught here, once it has become PC
                    fault_next      = 1'b1;
                    fault_code_next = CODE_MISALIGN;
                    state_next      = ST_FAULT;
                end else begin
                    mem_addr_next = pc_reg;
                    mem_read_next = 1'b1;
                    timer_next    = '0;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (MFC) begin
                    ir_next       = mem_data;
                    ir_valid_next = 1'b1;
                    mem_read_next = 1'b0;
                    state_next    = ST_ISSUE;
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                    if (timer_reg == TIMER_LAST) begin
                        mem_read_next   = 1'b0;
                        fault_next      = 1'b1;
                        fault_code_next = CODE_TIMEOUT;
                        state_next      = ST_FAULT;
                    end
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    // Delay slot: the old nPC executes next, the redirect lands after it
                    ir_valid_next = 1'b0;
                    pc_next       = npc_reg;
                    npc_next      = redirect_valid ? redirect_addr : (npc_reg + 32'd4);
                    state_next    = ST_FETCH;
                end
            end
            default: begin
                mem_read_next = 1'b0;
                ir_valid_next = 1'b0;
            end
        endcase
    end

    // The opcode bus is gated bit-by-bit by the read strobe so it reads zero when idle
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_opcode
            assign RAM_OpCode[gi] = RD_OPCODE[gi] & mem_read_reg;
        end
    endgenerate

    assign mem_addr   = mem_addr_reg;
    assign mem_read   = mem_read_reg;
    assign IR_Out     = ir_reg;
    assign ir_valid   = ir_valid_reg;
    assign PC_out     = pc_reg;
    assign nPC_out    = npc_reg;
    assign fault      = fault_reg;
    assign fault_code = fault_code_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit. A PC/nPC model pushes expected fetch
// addresses and instruction words to queues as stimulus is driven; a RAM
// responder pops and compares them when the DUT issues its read.
module tb_instruction_fetch_unit;

    localparam logic [5:0] OPC = 6'b100011;

    logic        Clk = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [5:0]  RAM_OpCode;
    logic        MFC = 1'b0;
    logic [31:0] mem_data = 32'd0;
    logic [31:0] IR_Out;
    logic        ir_valid;
    logic        exec_done = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'd0;
    logic [31:0] PC_out;
    logic [31:0] nPC_out;
    logic        fault;
    logic [1:0]  fault_code;

    int checks = 0;
    int failures = 0;

    logic [31:0] addr_q[$];
    logic [31:0] data_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_npc;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .MEM_TIMEOUT(16),
        .RD_OPCODE  (OPC)
    ) dut (
        .Clk           (Clk),
        .RESET         (RESET),
        .mem_addr      (mem_addr),
        .mem_read      (mem_read),
        .RAM_OpCode    (RAM_OpCode),
        .MFC           (MFC),
        .mem_data      (mem_data),
        .IR_Out        (IR_Out),
        .ir_valid      (ir_valid),
        .exec_done     (exec_done),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .PC_out        (PC_out),
        .nPC_out       (nPC_out),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0)
            return 32'h8200_4002;
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic tick;
        @(negedge Clk);
    endtask

    task automatic apply_reset;
        RESET = 1'b1;
        MFC = 1'b0;
        exec_done = 1'b0;
        redirect_valid = 1'b0;
        tick;
        RESET = 1'b0;
        addr_q.delete();
        data_q.delete();
        m_pc = 32'h0000_0000;
        m_npc = 32'h0000_0004;
        addr_q.push_back(m_pc);
    endtask

    task automatic fetch_one(input int wait_cycles, input string tag);
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        int n;
        n = 0;
        while (mem_read !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        checks++;
        if (mem_read !== 1'b1) begin
            failures++;
            $display("FAIL %s_read_timeout: mem_read=%b required 1", tag, mem_read);
            return;
        end
        exp_a = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hBAD0_BAD0;
        checks++;
        if (mem_addr !== exp_a) begin
            failures++;
            $display("FAIL %s_addr: mem_addr=%h required %h", tag, mem_addr, exp_a);
        end
        checks++;
        if (RAM_OpCode !== OPC) begin
            failures++;
            $display("FAIL %s_opcode: RAM_OpCode=%b required %b", tag, RAM_OpCode, OPC);
        end
        for (int i = 0; i < wait_cycles; i++) begin
            tick;
            checks++;
            if (mem_read !== 1'b1 || ir_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_wait_hold: mem_read=%b ir_valid=%b required 1 0", tag, mem_read, ir_valid);
            end
        end
        MFC = 1'b1;
        mem_data = mem_word(mem_addr);
        data_q.push_back(mem_word(exp_a));
        tick;
        MFC = 1'b0;
        mem_data = 32'hDEAD_BEEF;
        exp_d = data_q.pop_front();
        checks++;
        if (ir_valid !== 1'b1 || IR_Out !== exp_d) begin
            failures++;
            $display("FAIL %s_ir: ir_valid=%b IR_Out=%h required 1 %h", tag, ir_valid, IR_Out, exp_d);
        end
        checks++;
        if (mem_read !== 1'b0 || RAM_OpCode !== 6'd0) begin
            failures++;
            $display("FAIL %s_read_drop: mem_read=%b RAM_OpCode=%b required 0 0", tag, mem_read, RAM_OpCode);
        end
        $display("fetch %s addr=%h ir=%h wait=%0d", tag, mem_addr, IR_Out, wait_cycles);
    endtask

    task automatic execute(input logic redir, input logic [31:0] target, input string tag);
        exec_done = 1'b1;
        redirect_valid = redir;
        redirect_addr = target;
        m_pc = m_npc;
        m_npc = redir ? target : (m_npc + 32'd4);
        addr_q.push_back(m_pc);
        tick;
        exec_done = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || PC_out !== m_pc || nPC_out !== m_npc) begin
            failures++;
            $display("FAIL %s_advance: ir_valid=%b PC=%h nPC=%h required 0 %h %h",
                     tag, ir_valid, PC_out, nPC_out, m_pc, m_npc);
        end
        $display("exec %s redirect=%b target=%h -> PC=%h nPC=%h", tag, redir, target, PC_out, nPC_out);
    endtask

    task automatic test_reset;
        apply_reset;
        checks++;
        if (PC_out !== 32'd0 || nPC_out !== 32'd4 || ir_valid !== 1'b0 || IR_Out !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs: PC=%h nPC=%h ir_valid=%b IR=%h required 0 4 0 0",
                     PC_out, nPC_out, ir_valid, IR_Out);
        end
        checks++;
        if (mem_read !== 1'b0 || mem_addr !== 32'd0 || RAM_OpCode !== 6'd0 ||
            fault !== 1'b0 || fault_code !== 2'b00) begin
            failures++;
            $display("FAIL reset_mem: mem_read=%b mem_addr=%h op=%b fault=%b code=%b required all 0",
                     mem_read, mem_addr, RAM_OpCode, fault, fault_code);
        end
        tick;
        checks++;
        if (mem_read !== 1'b1) begin
            failures++;
            $display("FAIL reset_latency: mem_read=%b one edge after reset, required 1", mem_read);
        end
        fetch_one(0, "t1");
        checks++;
        if (IR_Out !== 32'h8200_4002 || PC_out !== 32'd0 || nPC_out !== 32'd4) begin
            failures++;
            $display("FAIL t1_first: IR=%h PC=%h nPC=%h required 82004002 0 4", IR_Out, PC_out, nPC_out);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] held_ir;
        execute(1'b0, 32'd0, "t2a");
        fetch_one(2, "t2a");
        execute(1'b0, 32'd0, "t2b");
        fetch_one(1, "t2b");
        checks++;
        if (PC_out !== 32'd8 || nPC_out !== 32'd12) begin
            failures++;
            $display("FAIL t2_pc: PC=%h nPC=%h required 8 c", PC_out, nPC_out);
        end
        held_ir = IR_Out;
        redirect_valid = 1'b1;
        redirect_addr = 32'h0000_0100;
        MFC = 1'b1;
        mem_data = 32'h0BAD_F00D;
        tick;
        tick;
        redirect_valid = 1'b0;
        MFC = 1'b0;
        checks++;
        if (ir_valid !== 1'b1 || IR_Out !== held_ir || PC_out !== 32'd8 || nPC_out !== 32'd12) begin
            failures++;
            $display("FAIL t2_ignored: ir_valid=%b IR=%h PC=%h nPC=%h required 1 %h 8 c",
                     ir_valid, IR_Out, PC_out, nPC_out, held_ir);
        end
        execute(1'b0, 32'd0, "t2c");
        fetch_one(0, "t2c");
    endtask

    task automatic test_delay_slot;
        apply_reset;
        fetch_one(0, "t3a");
        execute(1'b1, 32'h0000_0040, "t3a");
        fetch_one(0, "t3b");
        execute(1'b0, 32'd0, "t3b");
        fetch_one(0, "t3c");
        checks++;
        if (PC_out !== 32'h40 || nPC_out !== 32'h44) begin
            failures++;
            $display("FAIL t3_target: PC=%h nPC=%h required 40 44", PC_out, nPC_out);
        end
    endtask

    task automatic test_timeout;
        int cnt;
        apply_reset;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (mem_read === 1'b1)
                cnt++;
            if (fault === 1'b1)
                break;
        end
        checks++;
        if (cnt != 16) begin
            failures++;
            $display("FAIL t4_wait_cycles: observed=%0d required 16", cnt);
        end
        checks++;
        if (mem_read !== 1'b0 || fault !== 1'b1 || fault_code !== 2'b10) begin
            failures++;
            $display("FAIL t4_fault: mem_read=%b fault=%b code=%b required 0 1 10", mem_read, fault, fault_code);
        end
        exec_done = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 32'h80;
        MFC = 1'b1;
        for (int i = 0; i < 3; i++)
            tick;
        exec_done = 1'b0;
        redirect_valid = 1'b0;
        MFC = 1'b0;
        checks++;
        if (PC_out !== 32'd0 || nPC_out !== 32'd4 || fault !== 1'b1 || fault_code !== 2'b10 ||
            ir_valid !== 1'b0 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL t4_absorb: PC=%h nPC=%h fault=%b code=%b ir_valid=%b mem_read=%b required 0 4 1 10 0 0",
                     PC_out, nPC_out, fault, fault_code, ir_valid, mem_read);
        end
        $display("timeout wait_cycles=%0d fault_code=%b", cnt, fault_code);
    endtask

    task automatic test_misaligned;
        int rises;
        apply_reset;
        fetch_one(0, "t5a");
        execute(1'b1, 32'h0000_0042, "t5a");
        fetch_one(0, "t5b");
        execute(1'b0, 32'd0, "t5b");
        rises = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (mem_read !== 1'b0)
                rises++;
        end
        checks++;
        if (rises != 0 || fault !== 1'b1 || fault_code !== 2'b01 || PC_out !== 32'h42) begin
            failures++;
            $display("FAIL t5_misalign: read_cycles=%0d fault=%b code=%b PC=%h required 0 1 01 42",
                     rises, fault, fault_code, PC_out);
        end
        apply_reset;
        checks++;
        if (PC_out !== 32'd0 || fault !== 1'b0 || fault_code !== 2'b00) begin
            failures++;
            $display("FAIL t5_recover: PC=%h fault=%b code=%b required 0 0 00", PC_out, fault, fault_code);
        end
        $display("misalign fault cleared by reset PC=%h", PC_out);
    endtask

    task automatic test_reset_in_wait;
        apply_reset;
        tick;
        RESET = 1'b1;
        tick;
        RESET = 1'b0;
        MFC = 1'b1;
        mem_data = 32'h1234_5678;
        checks++;
        if (mem_read !== 1'b0 || IR_Out !== 32'd0) begin
            failures++;
            $display("FAIL t6_reset_drop: mem_read=%b IR=%h required 0 0", mem_read, IR_Out);
        end
        tick;
        MFC = 1'b0;
        checks++;
        if (IR_Out !== 32'd0 || ir_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 32'd0) begin
            failures++;
            $display("FAIL t6_late_mfc: IR=%h ir_valid=%b mem_read=%b mem_addr=%h required 0 0 1 0",
                     IR_Out, ir_valid, mem_read, mem_addr);
        end
        fetch_one(0, "t6a");
        execute(1'b1, 32'hFFFF_FFF8, "t6a");
        fetch_one(0, "t6b");
        execute(1'b0, 32'd0, "t6b");
        fetch_one(1, "t6c");
        execute(1'b0, 32'd0, "t6c");
        checks++;
        if (PC_out !== 32'hFFFF_FFFC || nPC_out !== 32'h0000_0000) begin
            failures++;
            $display("FAIL t6_wrap: PC=%h nPC=%h required fffffffc 0", PC_out, nPC_out);
        end
        fetch_one(0, "t6d");
    endtask

    initial begin
        tick;
        test_reset;
        test_sequential;
        test_delay_slot;
        test_timeout;
        test_misaligned;
        test_reset_in_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
